// File: rtl/dla_requant_pkg.sv
// Shared types and constants for the requantize / pool-feeder stage.
package dla_requant_pkg;

    localparam int unsigned PSUM_W  = 32;
    localparam int unsigned HWORD   = 16;
    localparam int unsigned SCALE_W = 16;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned PROD_W  = PSUM_W + SCALE_W;
    localparam int unsigned ACC_W   = PROD_W + 1;
    localparam int unsigned ROWW_W  = IDX_W + 1;
    localparam int unsigned CNT_W   = ROWW_W + 1;

    localparam logic signed [HWORD-1:0] HWORD_MAX = 16'sh7FFF;
    localparam logic signed [HWORD-1:0] HWORD_MIN = 16'sh8000;

    typedef struct packed {
        logic [SCALE_W-1:0]      scale;
        logic [SHIFT_W-1:0]      shift;
        logic signed [HWORD-1:0] zero_point;
        logic                    relu_en;
    } requant_cfg_t;

    // Column wrap point: odd widths round up to even, zero behaves as two.
    function automatic logic [CNT_W-1:0] eff_row_width(input logic [ROWW_W-1:0] rw);
        if (rw == '0) begin
            return CNT_W'(2);
        end else if (rw[0]) begin
            return {1'b0, rw} + CNT_W'(1);
        end else begin
            return {1'b0, rw};
        end
    endfunction

endpackage

// File: rtl/requant_pool_feeder_if.sv
// Psum input stream and pool-buffer write bus.
interface requant_pool_feeder_if;
    import dla_requant_pkg::*;

    logic signed [PSUM_W-1:0] psum;
    logic                     psum_valid;
    logic                     psum_ready;
    logic                     hold;
    logic signed [HWORD-1:0]  requan_result;
    logic [IDX_W-1:0]         pool_index;
    logic                     pool_wen;
    logic                     pool_last;

    modport master (
        output psum, psum_valid, hold,
        input  psum_ready, requan_result, pool_index, pool_wen, pool_last
    );

    modport slave (
        input  psum, psum_valid, hold,
        output psum_ready, requan_result, pool_index, pool_wen, pool_last
    );

endinterface

// File: rtl/requant_pool_feeder_requant_sat.sv
// Combinational round-half-up shift, zero-point add, optional ReLU and 16-bit saturation.
module requant_sat
    import dla_requant_pkg::*;
(
    input  logic signed [PROD_W-1:0] prod,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic signed [HWORD-1:0]  zero_point,
    input  logic                     relu_en,
    output logic signed [HWORD-1:0]  result_c
);

    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] half;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] biased;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        ext      = ACC_W'(prod);
        half     = (shift == '0) ? '0 : (ACC_W'(1) << (shift - SHIFT_W'(1)));
        shifted  = (ext + half) >>> shift;
        biased   = shifted + ACC_W'(zero_point);
        if (relu_en && biased[ACC_W-1]) begin
            biased = '0;
        end
        if (biased > ACC_W'(HWORD_MAX)) begin
            result_c = HWORD_MAX;
        end else if (biased < ACC_W'(HWORD_MIN)) begin
            result_c = HWORD_MIN;
        end else begin
            result_c = HWORD'(biased);
        end
    end

endmodule

// File: rtl/requant_pool_feeder.sv
// Three-stage requantizer feeding the 2x2 max-pool buffer with column index and window flags.
module requant_pool_feeder
    import dla_requant_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ROWW_W-1:0]       row_width,
    input  logic [SCALE_W-1:0]      scale,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic signed [HWORD-1:0] zero_point,
    input  logic                    relu_en,
    requant_pool_feeder_if.slave    bus,
    output logic                    frame_busy
);

    logic                     s1_valid;
    logic signed [PSUM_W-1:0] s1_psum;
    requant_cfg_t             s1_cfg;
    logic [ROWW_W-1:0]        s1_row_width;

    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_prod;
    logic [SHIFT_W-1:0]       s2_shift;
    logic signed [HWORD-1:0]  s2_zp;
    logic                     s2_relu;
    logic [ROWW_W-1:0]        s2_row_width;

    logic                     s3_valid;
    logic signed [HWORD-1:0]  out_result;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;

    logic [ROWW_W-1:0]        col;
    logic                     row_par;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [HWORD-1:0]  sat_c;
    logic                     emit_c;
    logic [CNT_W-1:0]         wrap_c;
    logic [CNT_W-1:0]         col_inc_c;

    assign prod_c    = PROD_W'(s1_psum) * PROD_W'($signed({1'b0, s1_cfg.scale}));
    assign emit_c    = s2_valid & ~bus.hold;
    assign wrap_c    = eff_row_width(s2_row_width);
    assign col_inc_c = {1'b0, col} + CNT_W'(1);

    requant_sat u_sat (
        .prod       (s2_prod),
        .shift      (s2_shift),
        .zero_point (s2_zp),
        .relu_en    (s2_relu),
        .result_c   (sat_c)
    );

    // Data pipeline: accept/multiply, then requantize into the output register; hold freezes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_psum      <= '0;
            s1_cfg       <= '0;
            s1_row_width <= '0;
            s2_valid     <= 1'b0;
            s2_prod      <= '0;
            s2_shift     <= '0;
            s2_zp        <= '0;
            s2_relu      <= 1'b0;
            s2_row_width <= '0;
            s3_valid     <= 1'b0;
            out_result   <= '0;
        end else if (!bus.hold) begin
            s1_valid <= bus.psum_valid;
            if (bus.psum_valid) begin
                s1_psum      <= bus.psum;
                s1_cfg       <= '{scale: scale, shift: shift, zero_point: zero_point, relu_en: relu_en};
                s1_row_width <= row_width;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod      <= prod_c;
                s2_shift     <= s1_cfg.shift;
                s2_zp        <= s1_cfg.zero_point;
                s2_relu      <= s1_cfg.relu_en;
                s2_row_width <= s1_row_width;
            end
            s3_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= sat_c;
            end
        end
    end

    // Band position: emit tags use the current position, then start clears or the column advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row_par   <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            if (emit_c) begin
                out_index <= IDX_W'(col >> 1);
                out_last  <= row_par & col[0];
            end
            if (start) begin
                col     <= '0;
                row_par <= 1'b0;
            end else if (emit_c) begin
                if (col_inc_c >= wrap_c) begin
                    col     <= '0;
                    row_par <= ~row_par;
                end else begin
                    col <= ROWW_W'(col_inc_c);
                end
            end
        end
    end

    assign bus.psum_ready    = ~bus.hold;
    assign bus.requan_result = out_result;
    assign bus.pool_index    = out_index;
    assign bus.pool_wen      = s3_valid & ~bus.hold;
    assign bus.pool_last     = out_last;
    assign frame_busy        = s1_valid | s2_valid | s3_valid;

endmodule

// File: tb/tb_requant_pool_feeder.sv
// Self-checking bench for requant_pool_feeder with an arithmetic reference model.
module tb_requant_pool_feeder;
    import dla_requant_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ROWW_W-1:0]       row_width;
    logic [SCALE_W-1:0]      scale;
    logic [SHIFT_W-1:0]      shift;
    logic signed [HWORD-1:0] zero_point;
    logic                    relu_en;
    logic                    frame_busy;

    requant_pool_feeder_if bus();

    requant_pool_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_width  (row_width),
        .scale      (scale),
        .shift      (shift),
        .zero_point (zero_point),
        .relu_en    (relu_en),
        .bus        (bus),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] result;
        int                 rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_col = 0;
    bit   model_par = 1'b0;

    int idx_tab[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int vec_psum[6]  = '{1000, 32'h7FFF_FFFF, -2000000, -2000000, -3, 5};
    int vec_scale[6] = '{3, 32'hFFFF, 100, 100, 1, 1};
    int vec_shift[6] = '{2, 0, 0, 0, 1, 1};
    int vec_zp[6]    = '{5, 0, 0, 0, 0, 0};
    int vec_relu[6]  = '{0, 0, 0, 1, 0, 0};
    int vec_exp[6]   = '{755, 32767, -32768, 0, -1, 3};

    // Requantization from the arithmetic definition in 64-bit integers.
    function automatic logic signed [15:0] ref_requant(input int p, input int unsigned sc,
                                                       input int unsigned sh, input int zp, input bit re);
        longint v;
        v = longint'(p) * longint'(sc);
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        v = v + longint'(zp);
        if (re && v < 0) v = 0;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Position model: column and row parity within the 2-row band, advanced per consumed output.
    task automatic model_take(input int rw, output int idx, output bit last);
        int wrap;
        wrap = (rw == 0) ? 2 : ((rw % 2 == 1) ? rw + 1 : rw);
        idx  = model_col / 2;
        last = model_par && (model_col % 2 == 1);
        model_col++;
        if (model_col >= wrap) begin
            model_col = 0;
            model_par = !model_par;
        end
    endtask

    // Drive one cycle of inputs at the falling edge; accepted entries enter the expectation queue.
    task automatic drive(input bit v, input int p, input bit h, input int sc, input int sh,
                         input int zp, input bit re);
        exp_t e;
        @(negedge clk);
        bus.psum_valid = v;
        bus.psum       = p;
        bus.hold       = h;
        scale          = 16'(sc);
        shift          = 5'(sh);
        zero_point     = 16'(zp);
        relu_en        = re;
        if (v && !h) begin
            e.result = ref_requant(p, 32'(scale), 32'(shift), int'(zero_point), re);
            e.rw     = int'(row_width);
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start          = 1'b1;
        bus.psum_valid = 1'b0;
        bus.hold       = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        model_col = 0;
        model_par = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.psum_valid = 1'b0; bus.hold = 1'b0; bus.psum = 0;
        row_width = 6'd4; scale = '0; shift = '0; zero_point = '0; relu_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.requan_result !== 16'sd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", bus.requan_result); end
        checks++; if (bus.pool_index !== 5'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", bus.pool_index); end
        checks++; if (bus.pool_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.pool_wen); end
        checks++; if (bus.pool_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.pool_last); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", frame_busy); end
        checks++; if (bus.psum_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.psum_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_requant_vectors();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vec_psum[i], 1'b0, vec_scale[i], vec_shift[i], vec_zp[i], vec_relu[i][0]);
            for (int k = 1; k <= 3; k++) begin
                idle();
                if (k < 3) begin
                    checks++; if (bus.pool_wen !== 1'b0) begin failures++; $display("FAIL vec%0d_early_wen cycle=%0d got=%b exp=0", i, k, bus.pool_wen); end
                end else begin
                    checks++; if (bus.pool_wen !== 1'b1) begin failures++; $display("FAIL vec%0d_wen got=%b exp=1", i, bus.pool_wen); end
                    checks++; if (bus.requan_result !== 16'(vec_exp[i])) begin failures++; $display("FAIL vec%0d_result got=%0d exp=%0d", i, bus.requan_result, vec_exp[i]); end
                end
            end
            void'(exp_q.pop_front());
        end
        idle();
    endtask

    task automatic test_back_to_back_index();
        exp_t e;
        int   idx, n, first_cyc, last_cyc;
        bit   last;
        n = 0; first_cyc = -1; last_cyc = -1;
        row_width = 6'd4;
        pulse_start();
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(1'b1, int'($urandom_range(0, 60000)) - 30000, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 20)), int'($urandom_range(0, 200)) - 100, 1'($urandom));
            else idle();
            if (bus.pool_wen) begin
                e = exp_q.pop_front();
                model_take(e.rw, idx, last);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                checks++; if (bus.requan_result !== e.result) begin failures++; $display("FAIL b2b_result n=%0d got=%0d exp=%0d", n, bus.requan_result, e.result); end
                checks++; if (bus.pool_index !== 5'(idx_tab[n % 8])) begin failures++; $display("FAIL b2b_index n=%0d got=%0d exp=%0d", n, bus.pool_index, idx_tab[n % 8]); end
                checks++; if (bus.pool_last !== (n == 5 || n == 7)) begin failures++; $display("FAIL b2b_last n=%0d got=%b exp=%b", n, bus.pool_last, (n == 5 || n == 7)); end
                n++;
            end
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", n); end
        checks++; if (last_cyc - first_cyc !== 7) begin failures++; $display("FAIL b2b_throughput span=%0d exp=7", last_cyc - first_cyc); end
    endtask

    task automatic test_hold_mid_stream();
        exp_t e;
        int   idx, n;
        bit   last;
        logic signed [15:0] held;
        n = 0; held = '0;
        row_width = 6'd8;
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            if (c < 3) drive(1'b1, 1000 * (c + 1), 1'b0, 3, 2, 5, 1'b0);
            else if (c < 5) drive(1'b1, 77777, 1'b1, 3, 2, 5, 1'b0);
            else idle();
            if (c == 3 || c == 4) begin
                checks++; if (bus.pool_wen !== 1'b0) begin failures++; $display("FAIL hold_wen c=%0d got=%b exp=0", c, bus.pool_wen); end
                checks++; if (bus.psum_ready !== 1'b0) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=0", c, bus.psum_ready); end
                if (c == 3) held = bus.requan_result;
                else begin
                    checks++; if (bus.requan_result !== held) begin failures++; $display("FAIL hold_frozen got=%0d exp=%0d", bus.requan_result, held); end
                end
            end
            if (bus.pool_wen) begin
                e = exp_q.pop_front();
                model_take(e.rw, idx, last);
                checks++; if (bus.requan_result !== e.result) begin failures++; $display("FAIL hold_result n=%0d got=%0d exp=%0d", n, bus.requan_result, e.result); end
                checks++; if (bus.pool_index !== 5'(idx)) begin failures++; $display("FAIL hold_index n=%0d got=%0d exp=%0d", n, bus.pool_index, idx); end
                n++;
            end
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL hold_count got=%0d exp=3", n); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL hold_drained_busy got=%b exp=0", frame_busy); end
    endtask

    task automatic test_random_stream();
        exp_t e;
        int   idx, rw_tab[3], p;
        bit   last, v, h;
        rw_tab[0] = 0; rw_tab[1] = 5; rw_tab[2] = int'($urandom_range(1, 63));
        for (int s = 0; s < 3; s++) begin
            row_width = 6'(rw_tab[s]);
            pulse_start();
            for (int c = 0; c < 160; c++) begin
                v = ($urandom_range(0, 9) < 7) && (c < 150);
                h = ($urandom_range(0, 9) < 2) && (c < 150);
                p = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
                drive(v, p, h, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 65535)) - 32768, 1'($urandom));
                if (h) begin
                    checks++; if (bus.pool_wen !== 1'b0) begin failures++; $display("FAIL rnd_hold_wen s=%0d c=%0d got=%b exp=0", s, c, bus.pool_wen); end
                end
                if (bus.pool_wen) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++; $display("FAIL rnd_extra_output s=%0d c=%0d got=%0d exp=none", s, c, bus.requan_result);
                    end else begin
                        e = exp_q.pop_front();
                        model_take(e.rw, idx, last);
                        if (bus.requan_result !== e.result) begin failures++; $display("FAIL rnd_result s=%0d c=%0d got=%0d exp=%0d", s, c, bus.requan_result, e.result); end
                        checks++; if (bus.pool_index !== 5'(idx)) begin failures++; $display("FAIL rnd_index s=%0d c=%0d got=%0d exp=%0d", s, c, bus.pool_index, idx); end
                        checks++; if (bus.pool_last !== last) begin failures++; $display("FAIL rnd_last s=%0d c=%0d got=%b exp=%b", s, c, bus.pool_last, last); end
                    end
                end
            end
            checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_lost s=%0d got=%0d exp=0 pending", s, exp_q.size()); end
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   idx, n;
        bit   last;
        row_width = 6'd2;
        pulse_start();
        for (int c = 0; c < 4; c++) drive(1'b1, 1000, 1'b0, 3, 2, 5, 1'b0);
        checks++; if (bus.pool_wen !== 1'b1 || bus.requan_result !== 16'sd755) begin failures++; $display("FAIL arst_pre got=%b/%0d exp=1/755", bus.pool_wen, bus.requan_result); end
        checks++; if (frame_busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", frame_busy); end
        bus.psum_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.requan_result !== 16'sd0) begin failures++; $display("FAIL arst_result got=%0d exp=0", bus.requan_result); end
        checks++; if (bus.pool_wen !== 1'b0) begin failures++; $display("FAIL arst_wen got=%b exp=0", bus.pool_wen); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", frame_busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        row_width = 6'd4;
        pulse_start();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, int'($urandom_range(0, 2000)), 1'b0, 1, 0, 0, 1'b0);
            else idle();
            if (bus.pool_wen) begin
                e = exp_q.pop_front();
                model_take(e.rw, idx, last);
                checks++; if (bus.pool_index !== 5'(idx_tab[n])) begin failures++; $display("FAIL arst_index n=%0d got=%0d exp=%0d", n, bus.pool_index, idx_tab[n]); end
                checks++; if (bus.requan_result !== e.result) begin failures++; $display("FAIL arst_result2 n=%0d got=%0d exp=%0d", n, bus.requan_result, e.result); end
                n++;
            end
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL arst_count got=%0d exp=4", n); end
    endtask

    initial begin
        test_reset();
        test_requant_vectors();
        test_back_to_back_index();
        test_hold_mid_stream();
        test_random_stream();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
